// File: rtl/palette_loader_pkg.sv
// Shared palette geometry: index/data widths and the 12-bit color layout.
// Pulled into the loader with a package import.
package palette_loader_pkg;

    localparam int PAL_IDX_W  = 8;
    localparam int PAL_DATA_W = 16;

    localparam int COLOR_W = 12;
    localparam int R_HI    = 11;
    localparam int R_LO    = 8;
    localparam int G_HI    = 7;
    localparam int G_LO    = 4;
    localparam int B_HI    = 3;
    localparam int B_LO    = 0;

endpackage

// File: rtl/palette_loader.sv
// Host byte stream to palette RAM write engine: index byte, then hi/lo
// color byte pairs, one active-low strobe per entry with auto-increment.
module palette_loader
    import palette_loader_pkg::*;
#(
    parameter int IDX_W  = PAL_IDX_W,
    parameter int DATA_W = PAL_DATA_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_first,
    input  logic              wr_allow,
    output logic              wr,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_STROBE
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               wr_q, wr_d;
    logic               take;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_HI) ||
                      (state_q == S_LO);
    assign busy     = (state_q == S_WRITE) || (state_q == S_STROBE);
    assign take     = in_valid && in_ready;

    assign wr      = wr_q;
    assign wr_addr = addr_q;
    // Zero-extension keeps the unused top nibble of each entry at 0.
    assign wr_data = DATA_W'(color_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        color_d = color_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (take && in_first) begin
                    addr_d  = IDX_W'(in_byte);
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (take) begin
                    if (in_first) begin
                        addr_d = IDX_W'(in_byte);
                    end else begin
                        color_d[R_HI:R_LO] = in_byte[R_HI-R_LO:0];
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (take) begin
                    if (in_first) begin
                        addr_d  = IDX_W'(in_byte);
                        state_d = S_HI;
                    end else begin
                        color_d[G_HI:B_LO] = in_byte;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_allow) begin
                    wr_d    = 1'b0;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                wr_d    = 1'b1;
                addr_d  = addr_q + IDX_W'(1);
                state_d = S_HI;
            end
            default: begin
                wr_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            color_q <= '0;
            wr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            color_q <= color_d;
            wr_q    <= wr_d;
        end
    end

endmodule
